// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: widths, fetch FSM states and the IF/ID bundle.
package pipeline_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic {
    FS_RUN,
    FS_HOLD
  } fetch_state_e;

  typedef struct packed {
    logic               valid;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus1;
    logic [INSTR_W-1:0] instr;
  } if_id_t;

  // A bubble always carries NOP_INSTR so decode can ignore valid.
  function automatic if_id_t make_ifid(
    input logic               v,
    input logic [ADDR_W-1:0]  pc,
    input logic [INSTR_W-1:0] word
  );
    if_id_t r;
    r.valid    = v;
    r.pc       = pc;
    r.pc_plus1 = pc + ADDR_W'(1);
    r.instr    = v ? word : NOP_INSTR;
    return r;
  endfunction

endpackage

// File: rtl/pc_register.sv
// Fetch program counter: async reset, load on redirect, increment, else hold.
module pc_register
  import pipeline_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc_q
);

  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      load:    pc_d = load_pc;
      inc:     pc_d = pc_q + ADDR_W'(1);
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives the 1-cycle InstructionMemory, pairs words with PCs
// into IF/ID, absorbs stalls and restarts on redirects.
module instruction_fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_instr,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               ifid_valid,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [ADDR_W-1:0]  ifid_pc_plus1,
  output logic [INSTR_W-1:0] ifid_instr
);

  fetch_state_e       fsm_q, fsm_d;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  infl_pc_q, infl_pc_d;
  logic               infl_v_q, infl_v_d;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
  if_id_t             ifid_q, ifid_d;
  logic               pc_load, pc_inc;

  pc_register #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk    (clk),
    .reset  (reset),
    .load   (pc_load),
    .load_pc(redirect_pc),
    .inc    (pc_inc),
    .pc_q   (pc_q)
  );

  always_comb begin
    fsm_d        = fsm_q;
    infl_pc_d    = infl_pc_q;
    infl_v_d     = infl_v_q;
    hold_instr_d = hold_instr_q;
    ifid_d       = ifid_q;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;
    if (redirect) begin
      pc_load      = 1'b1;
      infl_v_d     = 1'b0;
      ifid_d.valid = 1'b0;
      ifid_d.instr = NOP_INSTR;
      fsm_d        = FS_RUN;
    end else begin
      unique case (fsm_q)
        FS_RUN: begin
          if (stall) begin
            // Memory moves on to pc_q; keep the in-flight word.
            hold_instr_d = mem_instr;
            fsm_d        = FS_HOLD;
          end else begin
            ifid_d    = make_ifid(infl_v_q, infl_pc_q, mem_instr);
            pc_inc    = 1'b1;
            infl_pc_d = pc_q;
            infl_v_d  = 1'b1;
          end
        end
        FS_HOLD: begin
          if (!stall) begin
            ifid_d    = make_ifid(infl_v_q, infl_pc_q, hold_instr_q);
            pc_inc    = 1'b1;
            infl_pc_d = pc_q;
            infl_v_d  = 1'b1;
            fsm_d     = FS_RUN;
          end
        end
        default: fsm_d = FS_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q        <= FS_RUN;
      infl_pc_q    <= '0;
      infl_v_q     <= 1'b0;
      hold_instr_q <= NOP_INSTR;
      ifid_q       <= make_ifid(1'b0, '0, NOP_INSTR);
    end else begin
      fsm_q        <= fsm_d;
      infl_pc_q    <= infl_pc_d;
      infl_v_q     <= infl_v_d;
      hold_instr_q <= hold_instr_d;
      ifid_q       <= ifid_d;
    end
  end

  assign mem_addr      = pc_q;
  assign ifid_valid    = ifid_q.valid;
  assign ifid_pc       = ifid_q.pc;
  assign ifid_pc_plus1 = ifid_q.pc_plus1;
  assign ifid_instr    = ifid_q.instr;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit with a 1-cycle synchronous memory model.
module tb_instruction_fetch_unit;
  import pipeline_pkg::*;

  localparam logic [15:0] WA = 16'hA0A0;
  localparam logic [15:0] WB = 16'hB0B1;
  localparam logic [15:0] WC = 16'hC0C2;
  localparam logic [15:0] WD = 16'hD0D3;
  localparam logic [15:0] WE = 16'hE0E4;
  localparam logic [15:0] WF = 16'hF0F5;
  localparam logic [15:0] W41 = 16'h3C41;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        ev;
    logic [15:0] epc;
    logic [15:0] ei;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [15:0] mem_addr;
  logic [15:0] mem_instr;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ifid_valid;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_pc_plus1;
  logic [15:0] ifid_instr;

  logic [15:0] mem [0:65535];

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[$];
  vec_t exp_q[$];
  int   seg2;

  instruction_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .mem_addr     (mem_addr),
    .mem_instr    (mem_instr),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .ifid_valid   (ifid_valid),
    .ifid_pc      (ifid_pc),
    .ifid_pc_plus1(ifid_pc_plus1),
    .ifid_instr   (ifid_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_instr <= mem[mem_addr];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic r, input logic [15:0] rpc,
                     input logic ev, input logic [15:0] epc,
                     input logic [15:0] ei);
    vec_t v;
    v.stall = s;
    v.redir = r;
    v.rpc   = rpc;
    v.ev    = ev;
    v.epc   = epc;
    v.ei    = ei;
    vecs.push_back(v);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " mem_addr"}, 32'(mem_addr), 32'h0);
    check({tag, " valid"}, 32'(ifid_valid), 32'h0);
    check({tag, " pc"}, 32'(ifid_pc), 32'h0);
    check({tag, " pc_plus1"}, 32'(ifid_pc_plus1), 32'h1);
    check({tag, " instr"}, 32'(ifid_instr), 32'h0);
  endtask

  // Reset asserted between edges must act before the next edge.
  task automatic mid_reset();
    #2 reset = 1'b1;
    #1 check_reset_state("midrst");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h3C00;
    mem[16'h0000] = WA;
    mem[16'h0001] = WB;
    mem[16'h0002] = WC;
    mem[16'h0003] = WD;
    mem[16'h0040] = WE;
    mem[16'hFFFF] = WF;

    // Reset release, stall 3 cycles on (1,B), release.
    add(0, 0, 0, 0, 16'h0000, NOP_INSTR);
    add(0, 0, 0, 1, 16'h0000, WA);
    add(0, 0, 0, 1, 16'h0001, WB);
    add(1, 0, 0, 1, 16'h0001, WB);
    add(1, 0, 0, 1, 16'h0001, WB);
    add(1, 0, 0, 1, 16'h0001, WB);
    add(0, 0, 0, 1, 16'h0002, WC);
    add(0, 0, 0, 1, 16'h0003, WD);
    seg2 = vecs.size();
    // After mid-run reset: redirect to 0x40 while IF/ID=(2,C).
    add(0, 0, 0, 0, 16'h0000, NOP_INSTR);
    add(0, 0, 0, 1, 16'h0000, WA);
    add(0, 0, 0, 1, 16'h0001, WB);
    add(0, 0, 0, 1, 16'h0002, WC);
    add(0, 1, 16'h0040, 0, 16'h0000, NOP_INSTR);
    add(0, 0, 0, 0, 16'h0000, NOP_INSTR);
    add(0, 0, 0, 1, 16'h0040, WE);
    add(0, 0, 0, 1, 16'h0041, W41);
    // Redirect with stall held while in HOLD.
    add(1, 0, 0, 1, 16'h0041, W41);
    add(1, 1, 16'h0040, 0, 16'h0000, NOP_INSTR);
    add(0, 0, 0, 0, 16'h0000, NOP_INSTR);
    add(0, 0, 0, 1, 16'h0040, WE);
    // Wrap at the top of the address space.
    add(0, 1, 16'hFFFF, 0, 16'h0000, NOP_INSTR);
    add(0, 0, 0, 0, 16'h0000, NOP_INSTR);
    add(0, 0, 0, 1, 16'hFFFF, WF);
    add(0, 0, 0, 1, 16'h0000, WA);
    add(0, 0, 0, 1, 16'h0001, WB);

    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    #1 check_reset_state("rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t e;
      fetch_state_e efs;
      if (i == seg2) mid_reset();
      stall       = vecs[i].stall;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      efs = (e.stall && !e.redir) ? FS_HOLD : FS_RUN;
      check($sformatf("v%0d valid", i), 32'(ifid_valid), 32'(e.ev));
      check($sformatf("v%0d instr", i), 32'(ifid_instr), 32'(e.ei));
      check($sformatf("v%0d fsm", i), 32'(dut.fsm_q), 32'(efs));
      if (e.ev) begin
        check($sformatf("v%0d pc", i), 32'(ifid_pc), 32'(e.epc));
        check($sformatf("v%0d pc_plus1", i), 32'(ifid_pc_plus1),
              32'(16'(e.epc + 16'd1)));
      end
      if (e.redir)
        check($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(e.rpc));
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
